// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm set-point, mode FSM and ring/snooze control; ALARM_SNOOZE_EN enables the snooze feature.
module alarm_sequencer #(
  parameter int RING_SECS   = 5,
  parameter int SNOOZE_SECS = 10,
  parameter int SNOOZE_MAX  = 3
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       snooze_btn,
  input  logic       hourten,
  input  logic [3:0] hour,
  input  logic [2:0] minten,
  input  logic [3:0] min,
  output logic       alarm_hourten,
  output logic [3:0] alarm_hour,
  output logic [2:0] alarm_minten,
  output logic [3:0] alarm_min,
  output logic [2:0] state,
  output logic       disp_sel,
  output logic       armed,
  output logic       led
);
  typedef enum logic [2:0] {IDLE, SET_HOUR, SET_MIN, ARMED, RINGING, SNOOZE, UNUSED6, UNUSED7} state_t;
  state_t st, nxt;
  logic [1:0] btn_r, btn_p;
  logic [7:0] timer;
  logic mode_ev, inc_ev, snz_go, match, match_q, rise, expire;
  assign mode_ev = btn_r[1] & ~btn_p[1];
  assign inc_ev = btn_r[0] & ~btn_p[0];
  assign match = {hourten, hour, minten, min} == {alarm_hourten, alarm_hour, alarm_minten, alarm_min};
  assign rise = match & ~match_q;
  assign expire = timer == 8'd0;
  assign state = st;
`ifdef ALARM_SNOOZE_EN
  logic [2:0] snooze_cnt;
  logic snz_r, snz_p;
  assign snz_go = snz_r & ~snz_p & (snooze_cnt < 3'(SNOOZE_MAX));
  always_ff @(posedge clk_1Hz)
    if (rst) begin
      snz_r <= 1'b0;
      snz_p <= 1'b0;
      snooze_cnt <= 3'd0;
    end else begin
      snz_r <= snooze_btn;
      snz_p <= snz_r;
      if (nxt == IDLE || nxt == ARMED) snooze_cnt <= 3'd0;
      else if (st == RINGING && nxt == SNOOZE) snooze_cnt <= snooze_cnt + 3'd1;
    end
`else
  logic unused_snooze;
  assign unused_snooze = ^{snooze_btn, SNOOZE_SECS[0], SNOOZE_MAX[0]};
  assign snz_go = 1'b0;
`endif
  // Priority within each state: mode > snooze > match_rise > timer expiry
  always_comb begin
    nxt = IDLE;
    case (st)
      IDLE:     nxt = mode_ev ? SET_HOUR : IDLE;
      SET_HOUR: nxt = mode_ev ? SET_MIN : SET_HOUR;
      SET_MIN:  nxt = mode_ev ? ARMED : SET_MIN;
      ARMED:    nxt = mode_ev ? IDLE : rise ? RINGING : ARMED;
      RINGING:  nxt = mode_ev ? ARMED : snz_go ? SNOOZE : expire ? ARMED : RINGING;
`ifdef ALARM_SNOOZE_EN
      SNOOZE:   nxt = mode_ev ? ARMED : expire ? RINGING : SNOOZE;
`endif
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_1Hz)
    if (rst) begin
      st <= IDLE;
      led <= 1'b0;
      armed <= 1'b0;
      disp_sel <= 1'b0;
      alarm_hourten <= 1'b1;
      alarm_hour <= 4'd2;
      alarm_minten <= 3'd0;
      alarm_min <= 4'd0;
      timer <= 8'd0;
      btn_r <= 2'b00;
      btn_p <= 2'b00;
      match_q <= 1'b0;
    end else begin
      btn_r <= {mode_btn, inc_btn};
      btn_p <= btn_r;
      match_q <= match;
      st <= nxt;
      led <= nxt == RINGING;
      armed <= nxt inside {ARMED, RINGING, SNOOZE};
      disp_sel <= nxt inside {SET_HOUR, SET_MIN};
      if (nxt == RINGING && st != RINGING) timer <= 8'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
      else if (nxt == SNOOZE && st != SNOOZE) timer <= 8'(SNOOZE_SECS - 1);
`endif
      else if (!expire) timer <= timer - 8'd1;
      // 12-hour set-point: 12 wraps to 01, 09 carries into the tens digit
      if (st == SET_HOUR && !mode_ev && inc_ev)
        {alarm_hourten, alarm_hour} <= ({alarm_hourten, alarm_hour} == 5'h12) ? 5'h01 :
                                       (alarm_hour == 4'd9) ? 5'h10 : {alarm_hourten, alarm_hour + 4'd1};
      if (st == SET_MIN && !mode_ev && inc_ev)
        {alarm_minten, alarm_min} <= (alarm_min != 4'd9) ? {alarm_minten, alarm_min + 4'd1} :
                                     (alarm_minten == 3'd5) ? 7'h00 : {alarm_minten + 3'd1, 4'd0};
    end
endmodule
